// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings for the data-memory responder
package dmem_pkg;

    // Access size encodings carried in bhw[1:0]
    localparam logic [1:0] BHW_B = 2'b00;
    localparam logic [1:0] BHW_H = 2'b01;
    localparam logic [1:0] BHW_W = 2'b10;

    // bhw bit selecting zero-extension of sub-word loads
    localparam int BHW_UNSIGNED_BIT = 2;

    // Width of the latency down-counter (covers LATENCY up to 15)
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane extract/extend, write mask and alignment check
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  bhw_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_sh_o,
    output logic        misalign_o
);

    logic [31:0] shifted;
    logic        unsigned_ld;

    assign unsigned_ld = bhw_i[BHW_UNSIGNED_BIT];

    // Decode size: pick load lanes, extend, build byte mask, flag bad alignment
    always_comb begin
        shifted    = word_i >> {off_i, 3'b000};
        wdata_sh_o = wdata_i << {off_i, 3'b000};
        rdata_o    = '0;
        be_o       = '0;
        misalign_o = 1'b0;
        case (bhw_i[1:0])
            BHW_B: begin
                rdata_o = unsigned_ld ? {24'b0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
                be_o    = 4'b0001 << off_i;
            end
            BHW_H: begin
                misalign_o = off_i[0];
                rdata_o    = unsigned_ld ? {16'b0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
                be_o       = 4'b0011 << off_i;
            end
            BHW_W: begin
                misalign_o = (off_i != 2'b00);
                rdata_o    = shifted;
                be_o       = 4'b1111;
            end
            default: begin
                misalign_o = 1'b1;
            end
        endcase
        // An erroneous access must neither return data nor touch any lane
        if (misalign_o) begin
            rdata_o = '0;
            be_o    = '0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding load/store responder with fixed latency
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_bhw,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q;
    logic [2:0]         bhw_q;
    logic [ADDR_W+1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [31:0]        mem [DEPTH];
    logic [ADDR_W-1:0]  idx;
    logic [31:0]        cur_word;
    logic [31:0]        ld_data;
    logic [3:0]         be;
    logic [31:0]        wdata_sh;
    logic               misalign;
    logic [31:0]        merged;
    logic               accept;
    logic               commit;
    logic               mem_we;

    assign idx      = addr_q[ADDR_W+1:2];
    assign cur_word = mem[idx];

    dmem_lane_align u_lane_align (
        .word_i     (cur_word),
        .off_i      (addr_q[1:0]),
        .bhw_i      (bhw_q),
        .wdata_i    (wdata_q),
        .rdata_o    (ld_data),
        .be_o       (be),
        .wdata_sh_o (wdata_sh),
        .misalign_o (misalign)
    );

    // Handshake qualifiers; rst_n gate keeps req_ready low while reset is held
    assign req_ready  = rst_n && (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign accept     = req_valid && (state_q == IDLE);
    assign commit     = (state_q == BUSY) && (cnt_q == '0);
    assign mem_we     = commit && we_q && !misalign;

    // Merge shifted store data into the current word on enabled lanes only
    always_comb begin
        merged = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wdata_sh[8*i +: 8];
            end
        end
    end

    // Next state, latency count and response payload
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rdata_d = (we_q || misalign) ? 32'h0 : ld_data;
                    err_d   = misalign;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and response registers; reset drops any uncommitted store
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Capture the request fields at the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            bhw_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            bhw_q   <= req_bhw;
            addr_q  <= req_addr[ADDR_W+1:0];
            wdata_q <= req_wdata;
        end
    end

    // Storage array, deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= merged;
        end
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the functional units' load/store requests.
- Accepts one request at a time over a valid/ready handshake and performs byte, half or word access on an internal word array.
- Returns the sign- or zero-extended load data, or a store acknowledgement, after a fixed programmable latency.
- Sits between FU memory units and data storage; replaces direct fixed-latency RAM coupling with an explicit request/response protocol.

Parameters:
- ADDR_W, 10, word-index width; storage depth is 2**ADDR_W 32-bit words.
- LATENCY, 2, cycles from the request-accept edge to resp_valid rising. Legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assertion, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_bhw  in  3  bit2 = unsigned (loads only); bits[1:0]: 00 byte, 01 half, 10 word; 11 is illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned access or illegal bhw.

Behaviour:
- Reset (rst_n=0, any time):
  - State goes to IDLE; req_ready=0 while reset is asserted.
  - resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
  - Memory contents are not cleared.
  - An in-flight store whose commit edge has not occurred is dropped.
- States:
  - IDLE: req_ready=1. Accept occurs when req_valid&req_ready at an edge. On accept, capture we, bhw, addr, wdata; cnt<=LATENCY-1; go to BUSY.
  - BUSY: req_ready=0. If cnt!=0, decrement cnt. If cnt==0, perform the access, load the response registers, go to RESP.
  - RESP: resp_valid=1. Outputs are held stable until resp_valid&resp_ready at an edge, then return to IDLE. The next request cannot be accepted in the same cycle as the response handshake, so minimum throughput is one request per LATENCY+2 cycles.
- Timing: resp_valid rises exactly LATENCY edges after the accept edge, independent of resp_ready.
- Index: word index = addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo the depth.
- Alignment:
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - Byte is always aligned.
  - bhw[1:0]=11 is an error.
  - On error: no write, resp_err=1, resp_rdata=0.
- Loads: rdata = word >> (8*addr[1:0]), then truncate to 8/16/32 bits. Sign-extend when bhw[2]=0, zero-extend when bhw[2]=1. bhw[2] is ignored for word.
- Stores:
  - Byte-lane write. Byte: lane addr[1:0] <= wdata[7:0]. Half: lanes addr[1]*2+{0,1} <= wdata[15:0]. Word: all lanes.
  - Other lanes are unchanged. The write commits on the BUSY-to-RESP edge.
  - Response has resp_rdata=0, resp_err=0.
  - A load issued after a store's response completes sees the stored data.
- Protocol: req_* inputs are ignored outside IDLE. req_valid held in BUSY/RESP is not queued; the requester keeps it asserted until it sees req_ready.
- Simultaneous events: reset beats everything. req_valid while resp_valid is pending has no effect.

Decomposition:
- Package dmem_pkg holds:
  - BHW encodings: BHW_B=2'b00, BHW_H=2'b01, BHW_W=2'b10, plus the unsigned bit index 2.
  - State encoding: IDLE, BUSY, RESP.
  - Latency counter width 4.
- One combinational sub-module, dmem_lane_align. It takes the word, byte offset, bhw and wdata, and produces load extract/extend, the 4-bit byte-write mask, the shifted write data, and the misalign flag.
- The top level holds the FSM, the counter, the capture registers and the storage array.

Test Plan:
- LATENCY=2: store word 0xDEADBEEF @0x10; expect resp_valid exactly 2 edges after accept with resp_err=0. Then load word @0x10; expect resp_rdata=0xDEADBEEF.
- From that word, load byte signed @0x13 -> 0xFFFFFFDE. Load byte unsigned @0x13 -> 0x000000DE. Load half signed @0x12 -> 0xFFFFDEAD. Load half unsigned @0x10 -> 0x0000BEEF.
- Store byte 0x55 @0x11, then load word @0x10 -> 0xDEAD55EF. Store half 0x1234 @0x12, then load word -> 0x123455EF.
- Load half @0x11 and store word @0x12: both give resp_err=1, resp_rdata=0, and a subsequent load word @0x10 is unchanged. bhw=3'b011 gives resp_err=1.
- Hold resp_ready=0 for 5 cycles: resp_valid, resp_rdata and resp_err stay stable and req_ready=0. A second req_valid during this time is not accepted. Raise resp_ready: the response completes, req_ready=1 the next cycle, and the second request is accepted.
- Accept a store word 0xCAFEF00D @0x20 with prior content 0; assert rst_n=0 in the BUSY cycle. Expect resp_valid=0 immediately and the FSM in IDLE; after release, load @0x20 -> 0. Also check address wrap: with ADDR_W=10, store @0x1000 aliases @0x0.
